// File: rtl/regfile.sv
// Architectural register file with per-register rename tags.
// Resolves two source operands per cycle into a value or a producer tag.
module regfile #(
  parameter int unsigned ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 dec_ready,
  input  logic [4:0]           dec_rd,
  input  logic [ROB_WIDTH-1:0] dec_rob_id,
  input  logic [4:0]           dec_rs1,
  input  logic [4:0]           dec_rs2,
  input  logic                 commit_ready,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic [4:0]           commit_reg_id,
  input  logic [31:0]          commit_val,
  output logic                 search_has_dep_1,
  output logic [ROB_WIDTH-1:0] search_rob_id_1,
  output logic [31:0]          search_val_1,
  output logic                 search_has_dep_2,
  output logic [ROB_WIDTH-1:0] search_rob_id_2,
  output logic [31:0]          search_val_2
);

  localparam int unsigned NumRegs = 32;

  typedef struct packed {
    logic                 has_dep;
    logic [ROB_WIDTH-1:0] rob_id;
    logic [31:0]          val;
  } search_t;

  logic [31:0]          val_q [NumRegs];
  logic [31:0]          val_d [NumRegs];
  logic [NumRegs-1:0]   dep_q, dep_d;
  logic [ROB_WIDTH-1:0] tag_q [NumRegs];
  logic [ROB_WIDTH-1:0] tag_d [NumRegs];
  search_t              res_1, res_2;

  // Commit that retires the current owner of register s (used for bypass).
  function automatic search_t resolve(input logic [4:0] s);
    search_t r;
    r = '0;
    if (s == 5'd0) begin
      r = '0;
    end else if (commit_ready && commit_reg_id == s && dep_q[s] && tag_q[s] == commit_rob_id) begin
      r.val = commit_val;
    end else if (dep_q[s]) begin
      r.has_dep = 1'b1;
      r.rob_id  = tag_q[s];
    end else begin
      r.val = val_q[s];
    end
    return r;
  endfunction

  always_comb begin
    res_1 = resolve(dec_rs1);
    res_2 = resolve(dec_rs2);
    if (clear) begin
      res_1.has_dep = 1'b0;
      res_1.rob_id  = '0;
      res_2.has_dep = 1'b0;
      res_2.rob_id  = '0;
    end
  end

  always_comb begin
    val_d = val_q;
    dep_d = dep_q;
    tag_d = tag_q;
    if (commit_ready && commit_reg_id != 5'd0) begin
      val_d[commit_reg_id] = commit_val;
      // Only the youngest writer's commit releases the dependency.
      if (dep_q[commit_reg_id] && tag_q[commit_reg_id] == commit_rob_id) begin
        dep_d[commit_reg_id] = 1'b0;
      end
    end
    if (clear) begin
      dep_d = '0;
      for (int i = 0; i < NumRegs; i++) begin
        tag_d[i] = '0;
      end
    end else if (dec_ready && dec_rd != 5'd0) begin
      dep_d[dec_rd] = 1'b1;
      tag_d[dec_rd] = dec_rob_id;
    end
    val_d[0] = '0;
    dep_d[0] = 1'b0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NumRegs; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      dep_q            <= '0;
      search_has_dep_1 <= 1'b0;
      search_rob_id_1  <= '0;
      search_val_1     <= '0;
      search_has_dep_2 <= 1'b0;
      search_rob_id_2  <= '0;
      search_val_2     <= '0;
    end else if (rdy_in) begin
      val_q            <= val_d;
      dep_q            <= dep_d;
      tag_q            <= tag_d;
      search_has_dep_1 <= res_1.has_dep;
      search_rob_id_1  <= res_1.rob_id;
      search_val_1     <= res_1.val;
      search_has_dep_2 <= res_2.has_dep;
      search_rob_id_2  <= res_2.rob_id;
      search_val_2     <= res_2.val;
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed scenarios plus randomized traffic against a
// register/tag array model.
module tb_regfile;

  localparam int RW = 4;
  localparam int EW = 33 + RW;

  logic          clk = 1'b0, rst = 1'b1, rdy = 1'b1, clear = 1'b0;
  logic          dec_ready = 1'b0, commit_ready = 1'b0;
  logic [4:0]    dec_rd = '0, dec_rs1 = '0, dec_rs2 = '0, commit_reg_id = '0;
  logic [RW-1:0] dec_rob_id = '0, commit_rob_id = '0;
  logic [31:0]   commit_val = '0;
  logic          has1, has2;
  logic [RW-1:0] rob1, rob2;
  logic [31:0]   val1, val2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]   m_val [32];
  bit            m_dep [32];
  logic [RW-1:0] m_tag [32];
  logic [EW-1:0] e1, e2;

  regfile #(.ROB_WIDTH(RW)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clear),
    .dec_ready(dec_ready), .dec_rd(dec_rd), .dec_rob_id(dec_rob_id),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .commit_ready(commit_ready), .commit_rob_id(commit_rob_id),
    .commit_reg_id(commit_reg_id), .commit_val(commit_val),
    .search_has_dep_1(has1), .search_rob_id_1(rob1), .search_val_1(val1),
    .search_has_dep_2(has2), .search_rob_id_2(rob2), .search_val_2(val2)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] predict(input logic [4:0] s);
    if (s == 0) return '0;
    if (commit_ready && commit_reg_id == s && m_dep[s] && m_tag[s] == commit_rob_id)
      return {1'b0, {RW{1'b0}}, commit_val};
    if (m_dep[s]) return {1'b1, m_tag[s], 32'h0};
    return {1'b0, {RW{1'b0}}, m_val[s]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0;
      m_dep[i] = 1'b0;
      m_tag[i] = '0;
    end
    e1 = '0;
    e2 = '0;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic cyc();
    @(posedge clk);
    if (rdy && !rst) begin
      e1 = predict(dec_rs1);
      e2 = predict(dec_rs2);
      if (clear) begin
        e1[EW-1] = 1'b0;
        e1[32 +: RW] = '0;
        e2[EW-1] = 1'b0;
        e2[32 +: RW] = '0;
      end
      if (commit_ready && commit_reg_id != 0) begin
        m_val[commit_reg_id] = commit_val;
        if (m_dep[commit_reg_id] && m_tag[commit_reg_id] == commit_rob_id)
          m_dep[commit_reg_id] = 1'b0;
      end
      if (clear) begin
        for (int i = 0; i < 32; i++) begin
          m_dep[i] = 1'b0;
          m_tag[i] = '0;
        end
      end else if (dec_ready && dec_rd != 0) begin
        m_dep[dec_rd] = 1'b1;
        m_tag[dec_rd] = dec_rob_id;
      end
    end
    #1;
  endtask

  task automatic idle();
    dec_ready    = 1'b0;
    commit_ready = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic test_reset();
    dec_rs1 = 5'd3;
    dec_rs2 = 5'd0;
    cyc();
    n_tests++;
    if ({has1, rob1, val1} !== EW'(0)) begin
      n_fail++;
      $display("FAIL reset_rs1: got %h expected %h", {has1, rob1, val1}, EW'(0));
    end
    n_tests++;
    if ({has2, rob2, val2} !== EW'(0)) begin
      n_fail++;
      $display("FAIL reset_rs2: got %h expected %h", {has2, rob2, val2}, EW'(0));
    end
  endtask

  task automatic test_bypass();
    dec_ready = 1'b1; dec_rd = 5'd5; dec_rob_id = 4'd2;
    cyc();
    idle();
    dec_rs1 = 5'd5;
    cyc();
    n_tests++;
    if ({has1, rob1, val1} !== {1'b1, 4'd2, 32'h0}) begin
      n_fail++;
      $display("FAIL dep_x5: got %h expected %h", {has1, rob1, val1}, {1'b1, 4'd2, 32'h0});
    end
    commit_ready = 1'b1; commit_reg_id = 5'd5; commit_rob_id = 4'd2; commit_val = 32'h1234;
    cyc();
    n_tests++;
    if ({has1, rob1, val1} !== {1'b0, 4'd0, 32'h1234}) begin
      n_fail++;
      $display("FAIL bypass_x5: got %h expected %h", {has1, rob1, val1}, {1'b0, 4'd0, 32'h1234});
    end
    idle();
    cyc();
    n_tests++;
    if ({has1, rob1, val1} !== {1'b0, 4'd0, 32'h1234}) begin
      n_fail++;
      $display("FAIL after_commit_x5: got %h expected %h", {has1, rob1, val1},
               {1'b0, 4'd0, 32'h1234});
    end
  endtask

  task automatic test_older_commit();
    dec_ready = 1'b1; dec_rd = 5'd7; dec_rob_id = 4'd1;
    cyc();
    dec_rob_id = 4'd3;
    cyc();
    idle();
    commit_ready = 1'b1; commit_reg_id = 5'd7; commit_rob_id = 4'd1; commit_val = 32'hAA;
    dec_rs1 = 5'd7;
    cyc();
    idle();
    cyc();
    n_tests++;
    if ({has1, rob1, val1} !== {1'b1, 4'd3, 32'h0}) begin
      n_fail++;
      $display("FAIL older_commit_x7: got %h expected %h", {has1, rob1, val1}, {1'b1, 4'd3, 32'h0});
    end
    clear = 1'b1;
    cyc();
    idle();
    cyc();
    n_tests++;
    if ({has1, rob1, val1} !== {1'b0, 4'd0, 32'hAA}) begin
      n_fail++;
      $display("FAIL val_x7_after_clear: got %h expected %h", {has1, rob1, val1},
               {1'b0, 4'd0, 32'hAA});
    end
  endtask

  task automatic test_same_cycle();
    commit_ready = 1'b1; commit_reg_id = 5'd9; commit_rob_id = 4'd4; commit_val = 32'h55;
    dec_ready = 1'b1; dec_rd = 5'd9; dec_rob_id = 4'd6;
    dec_rs1 = 5'd9; dec_rs2 = 5'd9;
    cyc();
    idle();
    cyc();
    n_tests++;
    if ({has2, rob2, val2} !== {1'b1, 4'd6, 32'h0}) begin
      n_fail++;
      $display("FAIL issue_wins_x9: got %h expected %h", {has2, rob2, val2}, {1'b1, 4'd6, 32'h0});
    end
    commit_ready = 1'b1; commit_rob_id = 4'd6; commit_val = 32'h66;
    cyc();
    idle();
    cyc();
    n_tests++;
    if ({has1, rob1, val1} !== {1'b0, 4'd0, 32'h66}) begin
      n_fail++;
      $display("FAIL commit_x9: got %h expected %h", {has1, rob1, val1}, {1'b0, 4'd0, 32'h66});
    end
  endtask

  task automatic test_x0_and_clear();
    dec_ready = 1'b1; dec_rd = 5'd0; dec_rob_id = 4'd5;
    commit_ready = 1'b1; commit_reg_id = 5'd0; commit_rob_id = 4'd5; commit_val = 32'hDEAD;
    cyc();
    idle();
    dec_rs1 = 5'd0; dec_rs2 = 5'd0;
    cyc();
    n_tests++;
    if ({has1, rob1, val1, has2, rob2, val2} !== {2 * EW{1'b0}}) begin
      n_fail++;
      $display("FAIL x0_search: got %h %h expected 0", {has1, rob1, val1}, {has2, rob2, val2});
    end
    for (int i = 1; i <= 4; i++) begin
      commit_ready = 1'b1; commit_reg_id = 5'(i); commit_rob_id = 4'd0; commit_val = 32'h100 + i;
      cyc();
    end
    idle();
    for (int i = 1; i <= 4; i++) begin
      dec_ready = 1'b1; dec_rd = 5'(i); dec_rob_id = 4'(i);
      cyc();
    end
    idle();
    clear = 1'b1; dec_ready = 1'b1; dec_rd = 5'd8; dec_rob_id = 4'd7;
    dec_rs1 = 5'd1; dec_rs2 = 5'd2;
    cyc();
    n_tests++;
    if ({has1, rob1, val1, has2, rob2, val2} !== {2 * EW{1'b0}}) begin
      n_fail++;
      $display("FAIL clear_cycle_search: got %h %h expected 0", {has1, rob1, val1},
               {has2, rob2, val2});
    end
    idle();
    cyc();
    n_tests++;
    if ({has1, val1, has2, val2} !== {1'b0, 32'h101, 1'b0, 32'h102}) begin
      n_fail++;
      $display("FAIL clear_x1_x2: got %h expected %h", {has1, val1, has2, val2},
               {1'b0, 32'h101, 1'b0, 32'h102});
    end
    dec_rs1 = 5'd3; dec_rs2 = 5'd4;
    cyc();
    n_tests++;
    if ({has1, val1, has2, val2} !== {1'b0, 32'h103, 1'b0, 32'h104}) begin
      n_fail++;
      $display("FAIL clear_x3_x4: got %h expected %h", {has1, val1, has2, val2},
               {1'b0, 32'h103, 1'b0, 32'h104});
    end
    dec_rs1 = 5'd8; dec_rs2 = 5'd0;
    cyc();
    n_tests++;
    if ({has1, rob1, val1} !== EW'(0)) begin
      n_fail++;
      $display("FAIL clear_drops_issue_x8: got %h expected %h", {has1, rob1, val1}, EW'(0));
    end
  endtask

  task automatic test_rdy_hold();
    dec_rs1 = 5'd2; dec_rs2 = 5'd1;
    cyc();
    rdy = 1'b0;
    commit_ready = 1'b1; commit_reg_id = 5'd2; commit_rob_id = 4'd0; commit_val = 32'h77;
    dec_rs1 = 5'd3; dec_rs2 = 5'd3;
    repeat (3) cyc();
    n_tests++;
    if ({val1, val2} !== {32'h102, 32'h101}) begin
      n_fail++;
      $display("FAIL rdy_hold_outputs: got %h expected %h", {val1, val2}, {32'h102, 32'h101});
    end
    rdy = 1'b1;
    idle();
    dec_rs1 = 5'd2; dec_rs2 = 5'd0;
    cyc();
    n_tests++;
    if ({has1, val1} !== {1'b0, 32'h102}) begin
      n_fail++;
      $display("FAIL rdy_hold_state_x2: got %h expected %h", {has1, val1}, {1'b0, 32'h102});
    end
  endtask

  task automatic test_async_reset();
    dec_rs1 = 5'd2; dec_rs2 = 5'd1;
    cyc();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if ({has1, rob1, val1, has2, rob2, val2} !== {2 * EW{1'b0}}) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %h %h expected 0", {has1, rob1, val1},
               {has2, rob2, val2});
    end
    #2;
    rst = 1'b0;
    cyc();
    n_tests++;
    if ({has1, rob1, val1, has2, rob2, val2} !== {2 * EW{1'b0}}) begin
      n_fail++;
      $display("FAIL async_reset_state: got %h %h expected 0", {has1, rob1, val1},
               {has2, rob2, val2});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rdy           = ($urandom_range(0, 9) != 0);
      clear         = ($urandom_range(0, 24) == 0);
      dec_ready     = $urandom_range(0, 1) == 1;
      dec_rd        = 5'($urandom_range(0, 31));
      dec_rob_id    = RW'($urandom);
      commit_ready  = $urandom_range(0, 1) == 1;
      commit_reg_id = 5'($urandom_range(0, 31));
      commit_rob_id = ($urandom_range(0, 2) != 0) ? m_tag[commit_reg_id] : RW'($urandom);
      commit_val    = $urandom;
      dec_rs1       = ($urandom_range(0, 2) == 0) ? commit_reg_id : 5'($urandom_range(0, 31));
      dec_rs2       = ($urandom_range(0, 2) == 0) ? dec_rd : 5'($urandom_range(0, 31));
      cyc();
      n_tests++;
      if ({has1, rob1, val1} !== e1) begin
        n_fail++;
        $display("FAIL random_rs1 cycle %0d: got %h expected %h", n, {has1, rob1, val1}, e1);
      end
      n_tests++;
      if ({has2, rob2, val2} !== e2) begin
        n_fail++;
        $display("FAIL random_rs2 cycle %0d: got %h expected %h", n, {has2, rob2, val2}, e2);
      end
    end
    idle();
    rdy = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    rst = 1'b0;
    test_reset();
    test_bypass();
    test_older_commit();
    test_same_cycle();
    test_x0_and_clear();
    test_rdy_hold();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
